// File: rtl/sram_bus_ctrl.sv
// sram_bus_ctrl: bridges a 68000-style 16-bit CPU bus to a 32-bit async SRAM
// built from two 16-bit chips. The FSM runs IDLE -> SETUP -> STROBE -> HOLD -> ACK.
// Ports: clk, reset (async, active high); CPU side: bus_addr, bus_data_in,
// bus_data_out, bus_as_n, bus_uds_n, bus_lds_n, bus_rw, bus_sel, bus_dtack_n.
// SRAM side: ram_addr, ram_data_read, ram_data_write, ram_data_is_output,
// ram_ce_n, ram_ub_n, ram_lb_n, ram_we_n, ram_oe_n. Index [0] is chip 0
// (data[15:0]) and index [1] is chip 1 (data[31:16]).
// Param WAIT_CYCLES (1..15) sets the strobe width in clk cycles.
// Optional macro SRAM_WRITE_POSTED_EN: a write is acknowledged as soon as it is
// latched, and the SRAM cycle then finishes in the background.
module sram_bus_ctrl #(
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [18:0] bus_addr,
  input  logic [15:0] bus_data_in,
  output logic [15:0] bus_data_out,
  input  logic        bus_as_n,
  input  logic        bus_uds_n,
  input  logic        bus_lds_n,
  input  logic        bus_rw,
  input  logic        bus_sel,
  output logic        bus_dtack_n,
  output logic [17:0] ram_addr,
  input  logic [31:0] ram_data_read,
  output logic [31:0] ram_data_write,
  output logic        ram_data_is_output,
  output logic [1:0]  ram_ce_n,
  output logic [1:0]  ram_ub_n,
  output logic [1:0]  ram_lb_n,
  output logic [1:0]  ram_we_n,
  output logic [1:0]  ram_oe_n
);

`ifdef SRAM_WRITE_POSTED_EN
  localparam bit POSTED = 1'b1;
`else
  localparam bit POSTED = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_HOLD,
    S_ACK
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;

  logic [18:0] addr_q, addr_d;
  logic [15:0] wdat_q, wdat_d;
  logic        rw_q, rw_d;
  logic        uds_n_q, uds_n_d;
  logic        lds_n_q, lds_n_d;

  logic [17:0] ram_addr_q, ram_addr_d;
  logic [31:0] ram_data_write_q, ram_data_write_d;
  logic        dio_q, dio_d;
  logic [1:0]  ce_n_q, ce_n_d;
  logic [1:0]  ub_n_q, ub_n_d;
  logic [1:0]  lb_n_q, lb_n_d;
  logic [1:0]  we_n_q, we_n_d;
  logic [1:0]  oe_n_q, oe_n_d;
  logic [15:0] dout_q, dout_d;
  logic        dtack_n_q, dtack_n_d;

  logic        accept;
  logic        busy_d;

  // A pending posted acknowledge (dtack still low) blocks re-accepting the
  // same, still-asserted CPU cycle.
  assign accept = (state_q == S_IDLE) && !bus_as_n && bus_sel &&
                  (!bus_uds_n || !bus_lds_n) && dtack_n_q;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) state_d = S_SETUP;
      end
      S_SETUP: begin
        state_d = S_STROBE;
        cnt_d   = 4'(WAIT_CYCLES);
      end
      S_STROBE: begin
        if (cnt_q <= 4'd1) state_d = S_HOLD;
        else cnt_d = cnt_q - 4'd1;
      end
      S_HOLD: begin
        state_d = (POSTED && !rw_q) ? S_IDLE : S_ACK;
      end
      S_ACK: begin
        if (bus_as_n) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic: the registered outputs are computed from the next state, so
  // each strobe changes on the edge that enters its phase.
  always_comb begin
    addr_d  = accept ? bus_addr    : addr_q;
    wdat_d  = accept ? bus_data_in : wdat_q;
    rw_d    = accept ? bus_rw      : rw_q;
    uds_n_d = accept ? bus_uds_n   : uds_n_q;
    lds_n_d = accept ? bus_lds_n   : lds_n_q;

    busy_d = (state_d == S_SETUP) || (state_d == S_STROBE) ||
             (state_d == S_HOLD);

    ram_addr_d       = ram_addr_q;
    ram_data_write_d = ram_data_write_q;
    dio_d            = 1'b0;
    ce_n_d           = 2'b11;
    ub_n_d           = 2'b11;
    lb_n_d           = 2'b11;
    we_n_d           = 2'b11;
    oe_n_d           = 2'b11;

    if (busy_d) begin
      ram_addr_d       = addr_d[18:1];
      ram_data_write_d = {wdat_d, wdat_d};
      dio_d            = !rw_d;
      ce_n_d = addr_d[0] ? 2'b01 : 2'b10;
      ub_n_d = addr_d[0] ? {uds_n_d, 1'b1} : {1'b1, uds_n_d};
      lb_n_d = addr_d[0] ? {lds_n_d, 1'b1} : {1'b1, lds_n_d};
      if (rw_d) oe_n_d = ce_n_d;
      else if (state_d == S_STROBE) we_n_d = ce_n_d;
    end

    // Read data is captured on the edge that leaves HOLD.
    dout_d = dout_q;
    if (state_q == S_HOLD && rw_q)
      dout_d = addr_q[0] ? ram_data_read[31:16] : ram_data_read[15:0];

    dtack_n_d = dtack_n_q;
    if (bus_as_n) dtack_n_d = 1'b1;
    if (state_q == S_ACK && !bus_as_n) dtack_n_d = 1'b0;
    if (POSTED && accept && !bus_rw) dtack_n_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q           <= '0;
      wdat_q           <= '0;
      rw_q             <= 1'b1;
      uds_n_q          <= 1'b1;
      lds_n_q          <= 1'b1;
      ram_addr_q       <= '0;
      ram_data_write_q <= '0;
      dio_q            <= 1'b0;
      ce_n_q           <= 2'b11;
      ub_n_q           <= 2'b11;
      lb_n_q           <= 2'b11;
      we_n_q           <= 2'b11;
      oe_n_q           <= 2'b11;
      dout_q           <= '0;
      dtack_n_q        <= 1'b1;
    end else begin
      addr_q           <= addr_d;
      wdat_q           <= wdat_d;
      rw_q             <= rw_d;
      uds_n_q          <= uds_n_d;
      lds_n_q          <= lds_n_d;
      ram_addr_q       <= ram_addr_d;
      ram_data_write_q <= ram_data_write_d;
      dio_q            <= dio_d;
      ce_n_q           <= ce_n_d;
      ub_n_q           <= ub_n_d;
      lb_n_q           <= lb_n_d;
      we_n_q           <= we_n_d;
      oe_n_q           <= oe_n_d;
      dout_q           <= dout_d;
      dtack_n_q        <= dtack_n_d;
    end
  end

  assign bus_data_out       = dout_q;
  assign bus_dtack_n        = dtack_n_q;
  assign ram_addr           = ram_addr_q;
  assign ram_data_write     = ram_data_write_q;
  assign ram_data_is_output = dio_q;
  assign ram_ce_n           = ce_n_q;
  assign ram_ub_n           = ub_n_q;
  assign ram_lb_n           = lb_n_q;
  assign ram_we_n           = we_n_q;
  assign ram_oe_n           = oe_n_q;

endmodule

// File: tb/tb_sram_bus_ctrl.sv
// tb_sram_bus_ctrl: scoreboard bench for sram_bus_ctrl.
// Two instances (WAIT_CYCLES 1 and 3) share one CPU bus.
module tb_sram_bus_ctrl;

`ifdef SRAM_WRITE_POSTED_EN
  localparam bit POSTED_TB = 1'b1;
`else
  localparam bit POSTED_TB = 1'b0;
`endif

  typedef struct packed {
    logic [1:0]  ce;
    logic [1:0]  ub;
    logic [1:0]  lb;
    logic [1:0]  we;
    logic [3:0]  len;
    logic [3:0]  we_len;
    logic [3:0]  oe_len;
    logic [3:0]  dio_len;
    logic [17:0] addr;
    logic [31:0] wdata;
  } acc_t;

  typedef struct packed {
    logic [31:0] cyc;
    logic        rd;
    logic [15:0] rdata;
  } ack_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [18:0] bus_addr = '0;
  logic [15:0] bus_data_in = '0;
  logic        bus_as_n = 1'b1;
  logic        bus_uds_n = 1'b1;
  logic        bus_lds_n = 1'b1;
  logic        bus_rw = 1'b1;
  logic        bus_sel = 1'b1;

  logic [15:0] dout [2];
  logic        dtack_n [2];
  logic [17:0] raddr [2];
  logic [31:0] rdr [2];
  logic [31:0] rdw [2];
  logic        dio [2];
  logic [1:0]  ce [2];
  logic [1:0]  ub [2];
  logic [1:0]  lb [2];
  logic [1:0]  we [2];
  logic [1:0]  oe [2];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  acc_t acc_q0[$];
  acc_t acc_q1[$];
  ack_t ack_q0[$];
  ack_t ack_q1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int wc(input int g);
    return (g == 0) ? 1 : 3;
  endfunction

  // dtack delay in edges after the request-sampling edge
  function automatic int lat(input int w, input bit rd);
    if (POSTED_TB && !rd) return 0;
    return w + 3;
  endfunction

  function automatic acc_t exp_acc(input int w, input logic [18:0] a,
                                   input logic [15:0] d, input bit rd,
                                   input bit u, input bit l);
    acc_t e;
    e.ce      = a[0] ? 2'b01 : 2'b10;
    e.ub      = a[0] ? {u, 1'b1} : {1'b1, u};
    e.lb      = a[0] ? {l, 1'b1} : {1'b1, l};
    e.we      = rd ? 2'b11 : e.ce;
    e.len     = 4'(w + 2);
    e.we_len  = rd ? 4'd0 : 4'(w);
    e.oe_len  = rd ? 4'(w + 2) : 4'd0;
    e.dio_len = rd ? 4'd0 : 4'(w + 2);
    e.addr    = a[18:1];
    e.wdata   = rd ? 32'h0 : {d, d};
    return e;
  endfunction

  task automatic chk(input string nm, input logic [79:0] act,
                     input logic [79:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_acc(input int g, input acc_t act);
    acc_t e;
    if ((g == 0 && acc_q0.size() == 0) || (g == 1 && acc_q1.size() == 0)) begin
      vectors++;
      miscompares++;
      $display("FAIL access_dut%0d: unexpected access %h expected none", g, act);
    end else begin
      e = (g == 0) ? acc_q0.pop_front() : acc_q1.pop_front();
      chk($sformatf("access_dut%0d", g), 80'(act), 80'(e));
    end
  endtask

  task automatic check_ack(input int g);
    ack_t e, a;
    if ((g == 0 && ack_q0.size() == 0) || (g == 1 && ack_q1.size() == 0)) begin
      vectors++;
      miscompares++;
      $display("FAIL dtack_dut%0d: unexpected dtack at cycle %0d expected none",
               g, cyc);
    end else begin
      e = (g == 0) ? ack_q0.pop_front() : ack_q1.pop_front();
      a.cyc   = cyc;
      a.rd    = e.rd;
      a.rdata = e.rd ? dout[g] : 16'h0;
      chk($sformatf("dtack_dut%0d", g), 80'(a), 80'(e));
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_dut
    sram_bus_ctrl #(.WAIT_CYCLES(g == 0 ? 1 : 3)) u_dut (
      .clk                (clk),
      .reset              (reset),
      .bus_addr           (bus_addr),
      .bus_data_in        (bus_data_in),
      .bus_data_out       (dout[g]),
      .bus_as_n           (bus_as_n),
      .bus_uds_n          (bus_uds_n),
      .bus_lds_n          (bus_lds_n),
      .bus_rw             (bus_rw),
      .bus_sel            (bus_sel),
      .bus_dtack_n        (dtack_n[g]),
      .ram_addr           (raddr[g]),
      .ram_data_read      (rdr[g]),
      .ram_data_write     (rdw[g]),
      .ram_data_is_output (dio[g]),
      .ram_ce_n           (ce[g]),
      .ram_ub_n           (ub[g]),
      .ram_lb_n           (lb[g]),
      .ram_we_n           (we[g]),
      .ram_oe_n           (oe[g])
    );

    assign rdr[g] = (raddr[g] == 18'h0) ? 32'h1234_5678
                                        : ({14'h0, raddr[g]} ^ 32'hA5A5_0F0F);

    acc_t cur;
    bit   in_acc = 1'b0;
    logic prev_dt = 1'b1;

    always @(negedge clk) begin
      if (reset) begin
        in_acc  = 1'b0;
        prev_dt = 1'b1;
      end else begin
        if (ce[g] != 2'b11) begin
          if (!in_acc) begin
            in_acc    = 1'b1;
            cur       = '0;
            cur.ce    = ce[g];
            cur.ub    = ub[g];
            cur.lb    = lb[g];
            cur.we    = 2'b11;
            cur.addr  = raddr[g];
            cur.wdata = dio[g] ? rdw[g] : 32'h0;
          end
          cur.len = cur.len + 4'd1;
          if (we[g] != 2'b11) begin
            cur.we     = we[g];
            cur.we_len = cur.we_len + 4'd1;
          end
          if (oe[g] != 2'b11) cur.oe_len = cur.oe_len + 4'd1;
          if (dio[g]) cur.dio_len = cur.dio_len + 4'd1;
        end else if (in_acc) begin
          in_acc = 1'b0;
          check_acc(g, cur);
        end
        if (!dtack_n[g] && prev_dt) check_ack(g);
        prev_dt = dtack_n[g];
      end
    end
  end

  // Drive a request at a negedge; expectations are queued for both DUTs.
  // ex0/ex1: extra edges before the DUT can accept (busy with earlier work).
  task automatic start_req(input logic [18:0] a, input logic [15:0] d,
                           input bit rd, input bit u, input bit l,
                           input int ex0, input int ex1,
                           input bit want_ack, input bit want_acc,
                           input logic [15:0] rdata);
    int   r;
    ack_t k;
    r = cyc + 1;
    bus_addr    = a;
    bus_data_in = d;
    bus_rw      = rd;
    bus_uds_n   = u;
    bus_lds_n   = l;
    bus_as_n    = 1'b0;
    for (int g = 0; g < 2; g++) begin
      if (want_acc) begin
        if (g == 0) acc_q0.push_back(exp_acc(wc(g), a, d, rd, u, l));
        else        acc_q1.push_back(exp_acc(wc(g), a, d, rd, u, l));
      end
      if (want_ack) begin
        k.cyc   = 32'(r + ((g == 0) ? ex0 : ex1) + lat(wc(g), rd));
        k.rd    = rd;
        k.rdata = rd ? rdata : 16'h0;
        if (g == 0) ack_q0.push_back(k);
        else        ack_q1.push_back(k);
      end
    end
  endtask

  task automatic end_req(input int low_cyc, input int idle_cyc);
    repeat (low_cyc) @(negedge clk);
    bus_as_n  = 1'b1;
    bus_uds_n = 1'b1;
    bus_lds_n = 1'b1;
    repeat (idle_cyc) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("rst_strobes_dut%0d", g),
          80'({ce[g], ub[g], lb[g], we[g], oe[g]}), 80'(10'h3FF));
      chk($sformatf("rst_dio_dtack_dut%0d", g),
          80'({dio[g], dtack_n[g]}), 80'(2'b01));
      chk($sformatf("rst_data_dut%0d", g),
          80'({raddr[g], rdw[g], dout[g]}), 80'(0));
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // word write, byte write to chip 1, two reads of word 0
    start_req(19'h00002, 16'hBEEF, 1'b0, 1'b0, 1'b0, 0, 0, 1'b1, 1'b1, 16'h0);
    end_req(10, 3);
    start_req(19'h00003, 16'h00A5, 1'b0, 1'b1, 1'b0, 0, 0, 1'b1, 1'b1, 16'h0);
    end_req(10, 3);
    start_req(19'h00001, 16'h0000, 1'b1, 1'b0, 1'b0, 0, 0, 1'b1, 1'b1, 16'h1234);
    end_req(10, 3);
    start_req(19'h00000, 16'h0000, 1'b1, 1'b0, 1'b0, 0, 0, 1'b1, 1'b1, 16'h5678);
    end_req(10, 3);

    // as_n dropped mid-STROBE: full WE pulse, no dtack unless posted
    start_req(19'h00010, 16'hC0DE, 1'b0, 1'b0, 1'b0, 0, 0, POSTED_TB, 1'b1, 16'h0);
    end_req(2, 10);
    start_req(19'h00000, 16'h0000, 1'b1, 1'b0, 1'b1, 0, 0, 1'b1, 1'b1, 16'h5678);
    end_req(10, 3);

    // reset during STROBE of a write
    start_req(19'h00020, 16'h5A5A, 1'b0, 1'b0, 1'b0, 0, 0, POSTED_TB, 1'b0, 16'h0);
    repeat (2) @(negedge clk);
    #1;
    reset    = 1'b1;
    bus_as_n = 1'b1;
    #1;
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("midrst_we_ce_dut%0d", g),
          80'({we[g], ce[g]}), 80'(4'hF));
      chk($sformatf("midrst_dio_dtack_dut%0d", g),
          80'({dio[g], dtack_n[g]}), 80'(2'b01));
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    start_req(19'h00001, 16'h0000, 1'b1, 1'b0, 1'b0, 0, 0, 1'b1, 1'b1, 16'h1234);
    end_req(10, 3);

`ifdef SRAM_WRITE_POSTED_EN
    // posted write then an immediate read; the read waits for the write's
    // SETUP+STROBE+HOLD plus the return to IDLE (W+1 extra edges)
    start_req(19'h00004, 16'h1111, 1'b0, 1'b0, 1'b0, 0, 0, 1'b1, 1'b1, 16'h0);
    @(negedge clk);
    bus_as_n  = 1'b1;
    bus_uds_n = 1'b1;
    bus_lds_n = 1'b1;
    @(negedge clk);
    start_req(19'h00000, 16'h0000, 1'b1, 1'b0, 1'b0, 2, 4, 1'b1, 1'b1, 16'h5678);
    end_req(20, 3);
`endif

    repeat (5) @(negedge clk);
    chk("leftover_acc_dut0", 80'(acc_q0.size()), 80'(0));
    chk("leftover_acc_dut1", 80'(acc_q1.size()), 80'(0));
    chk("leftover_ack_dut0", 80'(ack_q0.size()), 80'(0));
    chk("leftover_ack_dut1", 80'(ack_q1.size()), 80'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sram_bus_ctrl.md
Name: sram_bus_ctrl

Overview:
- Bridges the 68000-style 16-bit CPU bus inside `system` to the board's 32-bit asynchronous SRAM, built from two 16-bit chips.
- Sits directly upstream of the top-level SRAM pins and drives `ram_addr`, `ram_data_write`, `ram_data_is_output`, `ram_ce_n`, `ram_ub_n`, `ram_lb_n`, `ram_we_n` and `ram_oe_n`.
- Latches each CPU request, sequences SRAM strobes through a fixed-timing FSM, and returns `/DTACK`.

Parameters:
- WAIT_CYCLES, 1, number of clk cycles the strobe (WE or OE data-valid window) is held; legal range 1..15.

Ports:
- clk  in  1  system clock (divided board clock).
- reset  in  1  asynchronous, active-high reset.
- bus_addr  in  19  CPU word address A[19:1].
- bus_data_in  in  16  CPU write data.
- bus_data_out  out  16  read data returned to CPU.
- bus_as_n  in  1  address strobe, active low.
- bus_uds_n  in  1  upper byte strobe, active low.
- bus_lds_n  in  1  lower byte strobe, active low.
- bus_rw  in  1  1 = read, 0 = write.
- bus_sel  in  1  address decoder: RAM selected.
- bus_dtack_n  out  1  data acknowledge, active low.
- ram_addr  out  18  SRAM word address.
- ram_data_read  in  32  SRAM data in.
- ram_data_write  out  32  SRAM data out.
- ram_data_is_output  out  1  1 = drive the SRAM data pins.
- ram_ce_n  out  2  chip enables; [0] = chip 0 (data[15:0]), [1] = chip 1 (data[31:16]).
- ram_ub_n  out  2  per-chip upper-byte enables.
- ram_lb_n  out  2  per-chip lower-byte enables.
- ram_we_n  out  2  per-chip write enables.
- ram_oe_n  out  2  per-chip output enables.

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-high. All outputs are registered.
- Reset values: state IDLE; ram_ce_n, ram_ub_n, ram_lb_n, ram_we_n and ram_oe_n = 2'b11; ram_data_is_output = 0; ram_addr = 0; ram_data_write = 0; bus_data_out = 0; bus_dtack_n = 1.
- Request: in IDLE, a clk edge that sees bus_as_n = 0, bus_sel = 1 and (bus_uds_n = 0 or bus_lds_n = 0) latches addr, data, rw, uds_n and lds_n, then enters SETUP.
  - as_n low with both byte strobes high is ignored.
- Mapping:
  - ram_addr = bus_addr[18:1].
  - bus_addr[0] = 0 selects chip 0; bus_addr[0] = 1 selects chip 1.
  - ram_data_write = {bus_data_in, bus_data_in}.
  - The selected chip gets ub_n = uds_n and lb_n = lds_n; the other chip keeps ce_n, ub_n and lb_n high.
- SETUP (1 cycle):
  - Drive ce_n, ub_n, lb_n and addr.
  - Write: ram_data_is_output = 1 and we_n stays high.
  - Read: oe_n of the selected chip goes low.
- STROBE (WAIT_CYCLES cycles, 4-bit down counter): on a write, we_n of the selected chip is low. Then go to HOLD.
- HOLD (1 cycle):
  - we_n is high; data, addr and ce_n are still held.
  - Read: bus_data_out latches the selected half of ram_data_read at the end of HOLD.
  - Then go to ACK.
- ACK:
  - On ACK entry, release ce_n, oe_n, ub_n and lb_n and clear ram_data_is_output.
  - If bus_as_n = 0, bus_dtack_n = 0 and remains low until bus_as_n = 1 is sampled; then dtack_n = 1 and go to IDLE.
  - If bus_as_n is already high on entry, go straight to IDLE without asserting dtack.
- Latency: bus_dtack_n falls WAIT_CYCLES+3 clk edges after the request-sampling edge. With WAIT_CYCLES = 1, that is 4 edges.
- Abort: if bus_as_n rises mid-access, the SRAM cycle still completes through HOLD so that WE is never truncated; no dtack is given.
- Reset mid-access: all strobes go inactive immediately (asynchronously) and the FSM returns to IDLE.
- Back-to-back requests: a new request is accepted only in IDLE, so a minimum of 1 idle cycle follows each ACK.
- bus_data_out holds its last read value across writes and idle cycles.

Optional Feature:
- Macro: SRAM_WRITE_POSTED_EN.
- Enabled:
  - For writes, bus_dtack_n goes low on the edge entering SETUP (1 edge after request) and releases when as_n = 1 is sampled.
  - The SRAM sequence continues from the latched copy.
  - The FSM returns to IDLE after HOLD; a request arriving while busy waits until IDLE.
  - Reads are unchanged.
- Disabled: writes are acknowledged in ACK exactly like reads.

Test Plan:
- Reset asserted mid-STROBE of a write: ram_we_n = 2'b11, ram_ce_n = 2'b11, ram_data_is_output = 0 and bus_dtack_n = 1 before the next clk edge. After release, the FSM is in IDLE.
- Word write: addr 19'h00002, data 16'hBEEF, uds_n = lds_n = 0, WAIT_CYCLES = 1.
  - Required: ram_addr = 18'h00001, ram_ce_n = 2'b10, ram_we_n = 2'b10 for exactly 1 cycle, and ram_data_write[15:0] = 16'hBEEF.
  - bus_dtack_n falls 4 edges after the request.
- Byte write to chip 1: addr 19'h00003, uds_n = 1, lds_n = 0 -> ram_ce_n = 2'b01, ram_lb_n = 2'b01, ram_ub_n = 2'b11 during the access.
- Read: SRAM model returns 32'h1234_5678 at ram_addr 0.
  - addr 19'h00001 -> bus_data_out = 16'h1234.
  - addr 19'h00000 -> bus_data_out = 16'h5678.
  - ram_oe_n is low in SETUP through HOLD only.
- Abort: bus_as_n deasserted during STROBE of a write -> we_n pulse is still the full WAIT_CYCLES (sweep 1 and 3), bus_dtack_n never goes low, and the FSM returns to IDLE.
- With SRAM_WRITE_POSTED_EN: write request then an immediate read request.
  - Write dtack falls 1 edge after the request.
  - The read's SETUP starts only after the write's HOLD, and the read dtack timing matches the plain-read case.
